// File: rtl/exe_div_seq_pkg.sv
// ----------------------------------------------------------------------------
// exe_div_seq_pkg : shared encodings for the RV32M divide sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package exe_div_seq_pkg;

    // funct3 codes of the divide-class instructions
    localparam logic [2:0] C_INST_DIV  = 3'b100;
    localparam logic [2:0] C_INST_DIVU = 3'b101;
    localparam logic [2:0] C_INST_REM  = 3'b110;
    localparam logic [2:0] C_INST_REMU = 3'b111;

    localparam logic [6:0] C_INST_TYPE_R_M = 7'b0000001;

    localparam logic [31:0] C_ZERO          = 32'h0000_0000;
    localparam logic        C_WRITE_ENABLE  = 1'b1;
    localparam logic        C_WRITE_DISABLE = 1'b0;

    typedef logic [1:0] div_state_t;

    localparam div_state_t C_DIV_ST_IDLE = 2'd0;
    localparam div_state_t C_DIV_ST_CALC = 2'd1;
    localparam div_state_t C_DIV_ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/exe_div_seq_if.sv
// ----------------------------------------------------------------------------
// exe_div_seq_if : ID/EX issue and write-back signals of the divide sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface exe_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic [4:0]       rd_i;
    logic             flush_i;
    logic             stall_o;
    logic             busy_o;
    logic [WIDTH-1:0] result_o;
    logic             reg_we_o;
    logic [4:0]       reg_waddr_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, rd_i, flush_i,
        input  stall_o, busy_o, result_o, reg_we_o, reg_waddr_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, rd_i, flush_i,
        output stall_o, busy_o, result_o, reg_we_o, reg_waddr_o
    );
endinterface

`default_nettype wire

// File: rtl/exe_div_iter.sv
// ----------------------------------------------------------------------------
// exe_div_iter : one combinational radix-2 restoring division step
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module exe_div_iter #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_rem,
    input  wire logic [WIDTH-1:0] i_quo,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_rem,
    output logic      [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shift;
    logic           w_ge;

    // The shifted partial remainder needs one extra bit; the difference always fits in WIDTH.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});
    assign o_rem   = w_ge ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];
    assign o_quo   = {i_quo[WIDTH-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/exe_div_seq.sv
// ----------------------------------------------------------------------------
// exe_div_seq : multi-cycle DIV/DIVU/REM/REMU sequencer for the execute stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module exe_div_seq
    import exe_div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic    clk_i,
    input  wire logic    rst_i,
    exe_div_seq_if.slave div_if
);
    localparam int               CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] C_ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_waddr;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_issue;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_special_res;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_fix_res;

    assign w_issue    = (r_state == C_DIV_ST_IDLE) && div_if.start_i && !div_if.flush_i;
    assign w_signed   = !div_if.op_i[0];
    assign w_a_neg    = w_signed && div_if.dividend_i[WIDTH-1];
    assign w_b_neg    = w_signed && div_if.divisor_i[WIDTH-1];
    assign w_a_mag    = w_a_neg ? (~div_if.dividend_i + 1'b1) : div_if.dividend_i;
    assign w_b_mag    = w_b_neg ? (~div_if.divisor_i + 1'b1) : div_if.divisor_i;
    assign w_div_zero = (div_if.divisor_i == '0);
    assign w_ovf      = w_signed && (div_if.dividend_i == C_MIN_NEG) && (div_if.divisor_i == C_ONES);

    // Divide-by-zero and signed overflow resolve at issue without iterating.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = div_if.op_i[1] ? div_if.dividend_i : C_ONES;
        end else begin
            w_special_res = div_if.op_i[1] ? '0 : C_MIN_NEG;
        end
    end

    exe_div_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    always_comb begin
        w_fix_res = '0;
        if (r_is_rem) begin
            w_fix_res = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
        end else begin
            w_fix_res = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= C_DIV_ST_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_waddr   <= '0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            case (r_state)
                C_DIV_ST_IDLE: begin
                    if (w_issue) begin
                        r_is_rem  <= div_if.op_i[1];
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_waddr   <= div_if.rd_i;
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_cnt     <= '0;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= C_DIV_ST_DONE;
                        end else begin
                            r_state  <= C_DIV_ST_CALC;
                        end
                    end
                end
                C_DIV_ST_CALC: begin
                    if (div_if.flush_i) begin
                        r_state <= C_DIV_ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_CNT_LAST) begin
                            r_result <= w_fix_res;
                            r_state  <= C_DIV_ST_DONE;
                        end
                    end
                end
                C_DIV_ST_DONE: begin
                    r_state <= C_DIV_ST_IDLE;
                end
                default: begin
                    r_state <= C_DIV_ST_IDLE;
                end
            endcase
        end
    end

    // Stall ends before DONE so the instruction leaves EX together with its write.
    assign div_if.stall_o     = rst_i && (w_issue || (r_state == C_DIV_ST_CALC));
    assign div_if.busy_o      = (r_state != C_DIV_ST_IDLE);
    assign div_if.reg_we_o    = ((r_state == C_DIV_ST_DONE) && !div_if.flush_i) ? C_WRITE_ENABLE
                                                                                : C_WRITE_DISABLE;
    assign div_if.result_o    = r_result;
    assign div_if.reg_waddr_o = r_waddr;

endmodule

`default_nettype wire
